// File: rtl/vchip8_pio_pkg.sv
// Shared constants for the vChip8 parallel I/O ports on the system interconnect.
// Holds the Avalon word map and the data bus width.
package vchip8_pio_pkg;

  localparam int BUS_W = 32;

  localparam logic [1:0] ADDR_DATA        = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK     = 2'd2;
  localparam logic [1:0] ADDR_EDGECAPTURE = 2'd3;

endpackage

// File: rtl/vchip8_debounce.sv
// Single-bit key conditioner: 2-FF synchroniser followed by a counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module vchip8_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  logic sync_p0;
  logic sync_p1;

  // Stage p0/p1: metastability synchroniser, reset to the idle level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= RESET_LEVEL;
      sync_p1 <= RESET_LEVEL;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
      assign stable = sync_p1;
    end else begin : g_db
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt;
      logic             stable_q;

      // Stage p2: the D-th consecutive differing sample commits the new level
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt      <= '0;
          stable_q <= RESET_LEVEL;
        end else if (sync_p1 != stable_q) begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            stable_q <= sync_p1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end

      assign stable = stable_q;
    end
  endgenerate

endmodule

// File: rtl/vchip8_key_pio.sv
// Avalon-MM push-button input port: debounced pressed state, press edge
// capture with write-1-to-clear, and a masked level interrupt.
module vchip8_key_pio
  import vchip8_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [BUS_W-1:0] writedata,
  output logic [BUS_W-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic RESET_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_stable;
  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] prev_pressed;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] ec_clr;
  logic             wr;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_key
      vchip8_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (RESET_LEVEL)
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (in_port[i]),
        .stable  (stable[i])
      );
    end

    if (WIDTH < BUS_W) begin : g_unused_hi
      logic unused_writedata_hi;
      assign unused_writedata_hi = ^writedata[BUS_W-1:WIDTH];
    end
  endgenerate

  assign pressed      = (ACTIVE_LOW != 0) ? ~stable : stable;
  assign prev_pressed = (ACTIVE_LOW != 0) ? ~prev_stable : prev_stable;
  assign rise         = pressed & ~prev_pressed;

  assign wr      = chipselect && !write_n;
  assign wr_bits = writedata[WIDTH-1:0];
  assign ec_clr  = (wr && address == ADDR_EDGECAPTURE) ? wr_bits : '0;

  // Stage p3: edge history and CPU-visible registers; a same-clock set beats a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_stable <= {WIDTH{RESET_LEVEL}};
      irq_mask    <= '0;
      edge_cap    <= '0;
    end else begin
      prev_stable <= stable;
      if (wr && address == ADDR_IRQMASK) begin
        irq_mask <= wr_bits;
      end
      edge_cap <= (edge_cap & ~ec_clr) | rise;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:        readdata[WIDTH-1:0] = pressed;
      ADDR_IRQMASK:     readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAPTURE: readdata[WIDTH-1:0] = edge_cap;
      default:          readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_vchip8_key_pio.sv
// Directed bench for vchip8_key_pio with WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
module tb_vchip8_key_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  vchip8_key_pio #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    #1;
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  // Write is committed on the next rising edge; returns 1 ns after it
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    write_n    = 1'b1;
    chipselect = 1'b0;
    writedata  = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // Reset
    tick(3);
    chk_rd("rst_in_reset_data", 2'd0, 32'h0);
    chk_irq("rst_in_reset_irq", 1'b0);
    reset_n = 1'b1;
    tick(2);
    chk_rd("rst_data", 2'd0, 32'h0);
    chk_rd("rst_resv", 2'd1, 32'h0);
    chk_rd("rst_mask", 2'd2, 32'h0);
    chk_rd("rst_ec",   2'd3, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // Clean press of key 2 from edge 0
    tick(1);
    in_port = 4'hB;
    tick(5);
    chk_rd("press_data_e5", 2'd0, 32'h0);
    tick(1);
    chk_rd("press_data_e6", 2'd0, 32'h4);
    chk_rd("press_ec_e6",   2'd3, 32'h0);
    tick(1);
    chk_rd("press_ec_e7",   2'd3, 32'h4);
    chk_irq("press_irq_masked", 1'b0);
    wr(2'd0, 32'hF);
    chk_rd("data_write_ignored", 2'd0, 32'h4);
    wr(2'd1, 32'hF);
    chk_rd("resv_write_ignored", 2'd1, 32'h0);

    // Release of key 2: DATA clears after 2+4, no capture on release
    in_port = 4'hF;
    tick(5);
    chk_rd("release_data_e5", 2'd0, 32'h4);
    tick(1);
    chk_rd("release_data_e6", 2'd0, 32'h0);
    tick(3);
    chk_rd("release_ec_keep", 2'd3, 32'h4);
    wr(2'd3, 32'hFFFF_FFFF);
    chk_rd("ec_clear_all", 2'd3, 32'h0);

    // Bounce rejection on key 0
    for (int r = 0; r < 5; r++) begin
      in_port = 4'hE;
      tick(3);
      in_port = 4'hF;
      tick(3);
      chk_rd("bounce_data", 2'd0, 32'h0);
    end
    chk_rd("bounce_ec", 2'd3, 32'h0);
    in_port = 4'hE;
    tick(6);
    chk_rd("hold_data", 2'd0, 32'h1);
    in_port = 4'hF;
    tick(8);
    chk_rd("hold_release_data", 2'd0, 32'h0);
    chk_rd("hold_ec", 2'd3, 32'h1);
    wr(2'd3, 32'hF);
    chk_rd("hold_ec_clr", 2'd3, 32'h0);

    // Interrupt and W1C
    wr(2'd2, 32'hFFFF_FFF5);
    chk_rd("mask_rd", 2'd2, 32'h5);
    in_port = 4'hC;
    tick(6);
    chk_irq("irq_before_capture", 1'b0);
    tick(1);
    chk_rd("irq_ec", 2'd3, 32'h3);
    chk_irq("irq_set", 1'b1);
    wr(2'd3, 32'h1);
    chk_rd("w1c_ec", 2'd3, 32'h2);
    chk_irq("w1c_irq_drop", 1'b0);
    wr(2'd3, 32'h0);
    chk_rd("w0_ec", 2'd3, 32'h2);
    wr(2'd2, 32'h2);
    chk_irq("mask_enable_irq", 1'b1);
    wr(2'd2, 32'h0);
    chk_irq("mask_disable_irq", 1'b0);
    in_port = 4'hF;
    tick(8);
    wr(2'd3, 32'hF);
    chk_rd("irq_ec_clr", 2'd3, 32'h0);

    // Set/clear collision on bit 3: capture lands on edge 7, W1C on the same edge
    in_port = 4'h7;
    tick(6);
    chk_rd("coll_ec_pre", 2'd3, 32'h0);
    wr(2'd3, 32'h8);
    chk_rd("coll_ec_set_wins", 2'd3, 32'h8);
    wr(2'd3, 32'h8);
    chk_rd("coll_ec_later_clr", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(8);
    chk_rd("coll_release", 2'd0, 32'h0);

    // Reset while a press of key 1 sits at count 2, key released
    in_port = 4'hD;
    tick(4);
    reset_n = 1'b0;
    in_port = 4'hF;
    tick(2);
    reset_n = 1'b1;
    tick(8);
    chk_rd("midrst_data", 2'd0, 32'h0);
    chk_rd("midrst_ec",   2'd3, 32'h0);

    // Reset at count 2 with key still held: the full 2+4 latency restarts
    in_port = 4'hD;
    tick(4);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(5);
    chk_rd("midrst_hold_e5", 2'd0, 32'h0);
    tick(1);
    chk_rd("midrst_hold_e6", 2'd0, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
